// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined register file and its scoreboard.
package regfile_pkg;

    localparam int          SP_IDX_DEF  = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'h2ffc;

    // Width of a counter that must hold 0..nregs inclusive.
    function automatic int pend_w(input int nregs);
        return $clog2(nregs + 1);
    endfunction

    // LSB of field k in a packed multi-port bus of w-bit fields.
    function automatic int port_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback, claim and debug.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int PW    = pend_w(NREGS)
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic                claim_ok;
    logic                flush;
    logic [PW-1:0]       pend_cnt;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    // Claim handshake: claim_en is the request (valid), claim_ok the same-cycle grant
    // (ready); ownership transfers only on a cycle where both are high. A refused
    // claim changes nothing and the requester simply holds claim_en/claim_addr.
    // wr_en is a fire-and-forget valid with no backpressure.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush, dbg_addr,
        input  rd_data, rd_busy, claim_ok, pend_cnt, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush, dbg_addr,
        output rd_data, rd_busy, claim_ok, pend_cnt, dbg_data
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for multi-cycle producers: claim/release handshake, flush, pending count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int PW    = pend_w(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              claim_en,
    input  logic [AW-1:0]     claim_addr,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic              claim_ok,
    output logic [NRD-1:0]    rd_busy,
    output logic [PW-1:0]     pend_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             claim_set;
    logic             release_hit;

    assign claim_ok  = claim_en && !flush && (claim_addr == '0 || !busy_q[claim_addr]);
    assign claim_set = claim_ok && (claim_addr != '0);
    // A release only shrinks the count when the bit was set and is not re-set this cycle.
    assign release_hit = wr_en && (wr_addr != '0) && busy_q[wr_addr]
                         && !(claim_set && claim_addr == wr_addr);

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        if (flush) begin
            busy_d = '0;
            pend_d = '0;
        end else begin
            if (wr_en) busy_d[wr_addr] = 1'b0;
            if (claim_set) busy_d[claim_addr] = 1'b1;
            busy_d[0] = 1'b0;
            pend_d = pend_q + PW'(claim_set) - PW'(release_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        assign rd_busy[k] = busy_q[rd_addr[port_lsb(k, AW) +: AW]];
    end

    assign pend_cnt = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with N combinational read ports, one write port, optional
// write-to-read bypass and a busy scoreboard for multi-cycle producers.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              AW      = $clog2(NREGS),
    parameter int              NRD     = 2,
    parameter int              BYPASS  = 1,
    parameter int              SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF)
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    localparam int PW = pend_w(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    always_comb begin
        rf_d = rf_q;
        if (bus.wr_en && bus.wr_addr != '0) rf_d[bus.wr_addr] = bus.wr_data;
    end

    // Writes land regardless of flush or busy state; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx = bus.rd_addr[port_lsb(k, AW) +: AW];
        assign bus.rd_data[port_lsb(k, XLEN) +: XLEN] =
            (idx == '0)                                      ? '0 :
            (BYPASS != 0 && bus.wr_en && bus.wr_addr == idx) ? bus.wr_data :
                                                               rf_q[idx];
    end

    assign bus.dbg_data = rf_q[bus.dbg_addr];

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD),
        .PW    (PW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .claim_en   (bus.claim_en),
        .claim_addr (bus.claim_addr),
        .flush      (bus.flush),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .claim_ok   (bus.claim_ok),
        .rd_busy    (bus.rd_busy),
        .pend_cnt   (bus.pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random bench for regfile_sb: bypassing and non-bypassing instances
// share stimulus and are checked against an array/popcount reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int PW    = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .PW(PW)) bus ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .PW(PW)) bus_nb ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb));

    assign bus_nb.rd_addr    = bus.rd_addr;
    assign bus_nb.wr_en      = bus.wr_en;
    assign bus_nb.wr_addr    = bus.wr_addr;
    assign bus_nb.wr_data    = bus.wr_data;
    assign bus_nb.claim_en   = bus.claim_en;
    assign bus_nb.claim_addr = bus.claim_addr;
    assign bus_nb.flush      = bus.flush;
    assign bus_nb.dbg_addr   = bus.dbg_addr;

    // Reference model: architectural values and the set of busy registers.
    logic [XLEN-1:0] m_rf [NREGS];
    bit              m_busy [NREGS];
    bit              m_ok = 1'b0;
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit bp);
        if (a == 0) return '0;
        if (bp && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return m_rf[a];
    endfunction

    function automatic bit m_grant();
        return bus.claim_en && !bus.flush && (bus.claim_addr == 0 || !m_busy[bus.claim_addr]);
    endfunction

    function automatic int m_pop();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic idle();
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.claim_en   = 1'b0;
        bus.claim_addr = '0;
        bus.flush      = 1'b0;
        bus.dbg_addr   = '0;
    endtask

    task automatic comb_check();
        logic [AW-1:0] a;
        if (!m_ok) return;
        for (int k = 0; k < NRD; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            chk($sformatf("rd_data%0d", k), bus.rd_data[k*XLEN +: XLEN], m_read(a, 1'b1));
            chk($sformatf("rd_data_nb%0d", k), bus_nb.rd_data[k*XLEN +: XLEN], m_read(a, 1'b0));
            chk($sformatf("rd_busy%0d", k), 32'(bus.rd_busy[k]), 32'(m_busy[a]));
        end
        chk("claim_ok", 32'(bus.claim_ok), 32'(m_grant()));
        chk("dbg_data", bus.dbg_data, m_rf[bus.dbg_addr]);
        chk("dbg_data_nb", bus_nb.dbg_data, m_rf[bus.dbg_addr]);
    endtask

    // One clock: check combinational outputs, advance the model on the edge, check the count.
    task automatic tick();
        bit g;
        #1 comb_check();
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_rf[i]   = (i == SP_IDX_DEF) ? SP_INIT_DEF : '0;
                m_busy[i] = 1'b0;
            end
            m_ok = 1'b1;
        end else if (m_ok) begin
            g = m_grant();
            if (bus.flush) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            end else begin
                if (bus.wr_en && bus.wr_addr != 0) m_busy[bus.wr_addr] = 1'b0;
                if (g && bus.claim_addr != 0) m_busy[bus.claim_addr] = 1'b1;
            end
            if (bus.wr_en && bus.wr_addr != 0) m_rf[bus.wr_addr] = bus.wr_data;
        end
        if (m_ok) begin
            chk("pend_cnt", 32'(bus.pend_cnt), m_pop());
            chk("pend_cnt_nb", 32'(bus_nb.pend_cnt), m_pop());
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state
        bus.dbg_addr = 5'd2;
        #1 chk("rst_x2", bus.dbg_data, 32'h2ffc);
        bus.dbg_addr = 5'd5;
        #1 chk("rst_x5", bus.dbg_data, 32'h0);
        chk("rst_pend", 32'(bus.pend_cnt), 32'h0);
        for (int a = 0; a < NREGS; a += 2) begin
            bus.rd_addr = {AW'(a + 1), AW'(a)};
            #1 chk("rst_busy", 32'(bus.rd_busy), 32'h0);
        end
        @(negedge clk);

        // Same-cycle write to x5 seen by read port 0
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        bus.rd_addr = {AW'(0), AW'(5)};
        #1 chk("byp_same", bus.rd_data[31:0], 32'hDEADBEEF);
        chk("nobyp_same", bus_nb.rd_data[31:0], 32'h0);
        tick();
        bus.wr_en = 1'b0;
        #1 chk("nobyp_next", bus_nb.rd_data[31:0], 32'hDEADBEEF);
        chk("byp_next", bus.rd_data[31:0], 32'hDEADBEEF);

        // x0 is hardwired
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        tick();
        idle();
        #1 chk("x0_read", bus.rd_data[63:32], 32'h0);
        chk("x0_dbg", bus.dbg_data, 32'h0);
        bus.claim_en = 1'b1; bus.claim_addr = 5'd0;
        #1 chk("claim_x0_ok", 32'(bus.claim_ok), 32'h1);
        tick();
        idle();
        #1 chk("claim_x0_pend", 32'(bus.pend_cnt), 32'h0);

        // Claim, refused re-claim, release of x7
        bus.claim_en = 1'b1; bus.claim_addr = 5'd7; bus.rd_addr = {AW'(0), AW'(7)};
        #1 chk("claim_x7_ok", 32'(bus.claim_ok), 32'h1);
        tick();
        bus.claim_en = 1'b0;
        #1 chk("claim_x7_pend", 32'(bus.pend_cnt), 32'h1);
        chk("claim_x7_busy", 32'(bus.rd_busy[0]), 32'h1);
        bus.claim_en = 1'b1;
        #1 chk("waw_x7_ok", 32'(bus.claim_ok), 32'h0);
        tick();
        bus.claim_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
        tick();
        idle();
        bus.rd_addr = {AW'(0), AW'(7)}; bus.dbg_addr = 5'd7;
        #1 chk("rel_x7_pend", 32'(bus.pend_cnt), 32'h0);
        chk("rel_x7_busy", 32'(bus.rd_busy[0]), 32'h0);
        chk("rel_x7_val", bus.dbg_data, 32'h55);

        // Several outstanding claims; release and claim of different registers together
        for (int r = 9; r <= 11; r++) begin
            idle();
            bus.claim_en = 1'b1; bus.claim_addr = AW'(r);
            tick();
        end
        idle();
        #1 chk("claim3_pend", 32'(bus.pend_cnt), 32'h3);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd12;
        tick();
        idle();
        #1 chk("swap_pend", 32'(bus.pend_cnt), 32'h3);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h12;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd12;
        #1 chk("reclaim_busy_ok", 32'(bus.claim_ok), 32'h0);
        tick();

        // Flush with a write and a claim in the same cycle
        idle();
        bus.claim_en = 1'b1; bus.claim_addr = 5'd3;
        tick();
        idle();
        bus.flush = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h77;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd4;
        #1 chk("flush_claim_ok", 32'(bus.claim_ok), 32'h0);
        tick();
        idle();
        bus.dbg_addr = 5'd3; bus.rd_addr = {AW'(4), AW'(3)};
        #1 chk("flush_pend", 32'(bus.pend_cnt), 32'h0);
        chk("flush_busy", 32'(bus.rd_busy), 32'h0);
        chk("flush_x3", bus.dbg_data, 32'h77);

        // Reset in the middle of claiming
        bus.claim_en = 1'b1; bus.claim_addr = 5'd5;
        tick();
        reset = 1'b1;
        bus.claim_addr = 5'd6;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h1111;
        tick();
        reset = 1'b0;
        idle();
        bus.dbg_addr = 5'd2; bus.rd_addr = {AW'(6), AW'(5)};
        #1 chk("rst2_x2", bus.dbg_data, 32'h2ffc);
        chk("rst2_pend", 32'(bus.pend_cnt), 32'h0);
        chk("rst2_busy", 32'(bus.rd_busy), 32'h0);

        // Random traffic over a narrow index range to force collisions
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.wr_en      = 1'($urandom_range(0, 1));
            bus.wr_addr    = AW'($urandom_range(0, 15));
            bus.wr_data    = $urandom;
            bus.claim_en   = 1'($urandom_range(0, 1));
            bus.claim_addr = AW'($urandom_range(0, 15));
            bus.rd_addr    = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            bus.dbg_addr   = AW'($urandom_range(0, NREGS - 1));
            tick();
        end
        reset = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
